// File: rtl/wb_arbiter.sv
// Two-master Wishbone classic arbiter: instruction and data masters share the
// RAM slave bus. Round-robin on ties from idle, grant held for the owner's whole
// cyc, zero-bubble handoff, and a watchdog that terminates un-acked strobes
// with err.
module wb_arbiter #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  // instruction master
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  input  logic [3:0]  inst_sel,
  input  logic        inst_we,
  input  logic        inst_cyc,
  input  logic        inst_stb,
  output logic [31:0] inst_rdata,
  output logic        inst_ack,
  output logic        inst_err,
  // data master
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  input  logic [3:0]  data_sel,
  input  logic        data_we,
  input  logic        data_cyc,
  input  logic        data_stb,
  output logic [31:0] data_rdata,
  output logic        data_ack,
  output logic        data_err,
  // RAM slave
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  output logic [3:0]  ram_sel,
  output logic        ram_we,
  output logic        ram_cyc,
  output logic        ram_stb,
  input  logic [31:0] ram_rdata,
  input  logic        ram_ack
);

  // Counter must be able to hold TIMEOUT itself; keep at least one bit so a
  // disabled watchdog still elaborates cleanly.
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, OWN_I, OWN_D} state_t;

  state_t        state_reg, state_next;
  logic          last_reg, last_next;   // 1: data master was granted most recently
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          owner_stb;
  logic          timeout;

  // Read data is broadcast; only ack/err tell a master the data is meant for it.
  assign inst_rdata = ram_rdata;
  assign data_rdata = ram_rdata;

  // Strobe of whichever master currently owns the bus (0 when idle).
  assign owner_stb = (state_reg == OWN_I) ? inst_stb :
                     (state_reg == OWN_D) ? data_stb : 1'b0;

  assign timeout = (TIMEOUT != 0) && (state_reg != IDLE) && (cnt_reg == TO_VAL);

  // State, round-robin pointer and watchdog registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      last_reg  <= 1'b1;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      last_reg  <= last_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Grant/release decisions and watchdog counting.
  always_comb begin
    state_next = state_reg;
    last_next  = last_reg;
    cnt_next   = '0;
    case (state_reg)
      IDLE: begin
        if (inst_cyc && (!data_cyc || last_reg)) begin
          state_next = OWN_I;
          last_next  = 1'b0;
        end else if (data_cyc) begin
          state_next = OWN_D;
          last_next  = 1'b1;
        end
      end
      OWN_I: begin
        if (!inst_cyc) begin
          if (data_cyc) begin
            state_next = OWN_D;
            last_next  = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end
      OWN_D: begin
        if (!data_cyc) begin
          if (inst_cyc) begin
            state_next = OWN_I;
            last_next  = 1'b0;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
    // Count only consecutive un-acked strobes within one ownership; a fired
    // timeout restarts the count so the master can retry or drop cyc.
    if ((state_next == state_reg) && (state_reg != IDLE) &&
        owner_stb && !ram_ack && !timeout) begin
      cnt_next = cnt_reg + CW'(1);
    end
  end

  // Bus mux toward the slave and termination routing back to the owner.
  always_comb begin
    ram_addr  = '0;
    ram_wdata = '0;
    ram_sel   = '0;
    ram_we    = 1'b0;
    ram_cyc   = 1'b0;
    ram_stb   = 1'b0;
    inst_ack  = 1'b0;
    inst_err  = 1'b0;
    data_ack  = 1'b0;
    data_err  = 1'b0;
    case (state_reg)
      OWN_I: begin
        ram_addr  = inst_addr;
        ram_wdata = inst_wdata;
        ram_sel   = inst_sel;
        ram_we    = inst_we;
        ram_cyc   = inst_cyc;
        ram_stb   = inst_stb & ~timeout;
        inst_ack  = ram_ack & ~timeout;
        inst_err  = timeout;
      end
      OWN_D: begin
        ram_addr  = data_addr;
        ram_wdata = data_wdata;
        ram_sel   = data_sel;
        ram_we    = data_we;
        ram_cyc   = data_cyc;
        ram_stb   = data_stb & ~timeout;
        data_ack  = ram_ack & ~timeout;
        data_err  = timeout;
      end
      default: ;
    endcase
  end

endmodule
